// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the CPU and the I/O poller.
// The CPU has priority, and the I/O port is guaranteed a grant after IO_MAX_WAIT denials.
// Optional grant statistics counters are enabled by defining ARB_STATS_EN.
module ram_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int IO_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
`ifdef ARB_STATS_EN
    output logic [31:0]   cpu_grant_cnt,
    output logic [31:0]   io_grant_cnt,
    output logic [15:0]   io_force_cnt,
`endif
    input  logic [DW-1:0] ram_q
);

    localparam int WW = (IO_MAX_WAIT < 1) ? 1 : $clog2(IO_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(IO_MAX_WAIT);

    // One-hot owner encoding: bit 0 = CPU read in flight, bit 1 = I/O read in flight.
    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_CPU  = 2'b01,
        RD_IO   = 2'b10
    } rd_owner_t;

    rd_owner_t     rd_owner_reg;
    rd_owner_t     rd_owner_next;
    logic [WW-1:0] wait_cnt_reg;
    logic [WW-1:0] wait_cnt_next;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic          io_force;
    logic          grant;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    always_comb begin
        io_force = (wait_cnt_reg == WAIT_MAX);
        cpu_gnt  = 1'b0;
        io_gnt   = 1'b0;
        // No grant may issue while reset is held.
        if (!reset) begin
            if (io_req && (io_force || !cpu_req)) begin
                io_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = cpu_gnt | io_gnt;
        win_we      = io_gnt ? io_we    : cpu_we;
        win_addr    = io_gnt ? io_addr  : cpu_addr;
        win_wdata   = io_gnt ? io_wdata : cpu_wdata;
        ram_wren    = grant & win_we;
        ram_address = grant ? win_addr  : addr_reg;
        ram_data    = grant ? win_wdata : data_reg;
    end

    always_comb begin
        wait_cnt_next = '0;
        if (io_req && !io_gnt) begin
            wait_cnt_next = io_force ? wait_cnt_reg : wait_cnt_reg + WW'(1);
        end
        rd_owner_next = RD_NONE;
        if (io_gnt && !io_we) begin
            rd_owner_next = RD_IO;
        end else if (cpu_gnt && !cpu_we) begin
            rd_owner_next = RD_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_reg <= RD_NONE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            rd_owner_reg <= rd_owner_next;
            wait_cnt_reg <= wait_cnt_next;
            if (grant) begin
                addr_reg <= win_addr;
                data_reg <= win_wdata;
            end
        end
    end

    // Per-requester read return: index 0 is the CPU, index 1 is the I/O poller.
    logic [1:0]         rvalid;
    logic [1:0][DW-1:0] rdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        logic [DW-1:0] rdata_reg;

        assign rvalid[gi] = !reset && rd_owner_reg[gi];
        assign rdata[gi]  = rvalid[gi] ? ram_q : rdata_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_reg <= '0;
            end else if (rvalid[gi]) begin
                rdata_reg <= ram_q;
            end
        end
    end

    assign cpu_rvalid = rvalid[0];
    assign io_rvalid  = rvalid[1];
    assign cpu_rdata  = rdata[0];
    assign io_rdata   = rdata[1];

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_grant_cnt <= '0;
            io_grant_cnt  <= '0;
            io_force_cnt  <= '0;
        end else begin
            if (cpu_gnt) begin
                cpu_grant_cnt <= cpu_grant_cnt + 32'd1;
            end
            if (io_gnt) begin
                io_grant_cnt <= io_grant_cnt + 32'd1;
            end
            if (io_gnt && io_force) begin
                io_force_cnt <= io_force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural 1-cycle RAM.
// Inputs change just after the rising edge, and outputs are compared on the falling edge.
module tb_ram_port_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, ram_wren;
    logic [31:0] cpu_rdata, io_rdata, ram_address, ram_data;
    logic [31:0] ram_q = 32'h0;
`ifdef ARB_STATS_EN
    logic [31:0] cpu_grant_cnt, io_grant_cnt;
    logic [15:0] io_force_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(32), .DW(32), .IO_MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
`ifdef ARB_STATS_EN
        .cpu_grant_cnt(cpu_grant_cnt), .io_grant_cnt(io_grant_cnt), .io_force_cnt(io_force_cnt),
`endif
        .ram_q(ram_q)
    );

    // Behavioural single-port RAM with read-before-write and 1-cycle latency.
    logic [31:0] mem [0:63] = '{0: 32'h11, 1: 32'h22, 2: 32'h33, default: 32'h0};
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address[5:0]] <= ram_data;
        ram_q <= mem[ram_address[5:0]];
    end

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        ir, iw;
        logic [31:0] ia, id;
        logic        ecg, eig, ewr;
        logic [31:0] ea, ed;
        logic        ecv, eiv;
        logic [31:0] ecd, eid;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_req = N; cpu_we = N; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        io_req  = N; io_we  = N; io_addr  = 32'h0; io_wdata  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag);
        $display("%s: cgnt=%b ignt=%b wren=%b addr=%0d data=%h crv=%b crd=%h irv=%b ird=%h",
                 tag, cpu_gnt, io_gnt, ram_wren, ram_address, ram_data,
                 cpu_rvalid, cpu_rdata, io_rvalid, io_rdata);
    endtask

    initial begin
        // cr cw ca cd | ir iw ia id | ecg eig ewr | ea ed | ecv eiv | ecd eid
        tbl[0]  = '{Y,N,32'd0,32'h0,  N,N,32'd0,32'h0,  Y,N,N, 32'd0, 32'h0, N,N, 32'h0,  32'h0};
        tbl[1]  = '{Y,N,32'd1,32'h0,  N,N,32'd0,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h11, 32'h0};
        tbl[2]  = '{Y,N,32'd2,32'h0,  N,N,32'd0,32'h0,  Y,N,N, 32'd2, 32'h0, Y,N, 32'h22, 32'h0};
        tbl[3]  = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd2, 32'h0, Y,N, 32'h33, 32'h0};
        tbl[4]  = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd2, 32'h0, N,N, 32'h33, 32'h0};
        tbl[5]  = '{Y,Y,32'd40,32'hDEADBEEF, N,N,32'd0,32'h0, Y,N,Y, 32'd40, 32'hDEADBEEF, N,N, 32'h33, 32'h0};
        tbl[6]  = '{N,N,32'd0,32'h0,  Y,N,32'd40,32'h0, N,Y,N, 32'd40, 32'h0, N,N, 32'h33, 32'h0};
        tbl[7]  = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd40, 32'h0, N,Y, 32'h33, 32'hDEADBEEF};
        tbl[8]  = '{N,N,32'd0,32'h0,  Y,Y,32'd5,32'hA5A50005, N,Y,Y, 32'd5, 32'hA5A50005, N,N, 32'h33, 32'hDEADBEEF};
        tbl[9]  = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd5, 32'hA5A50005, N,N, 32'h33, 32'hDEADBEEF};
        tbl[10] = '{N,N,32'd0,32'h0,  Y,N,32'd5,32'h0,  N,Y,N, 32'd5, 32'h0, N,N, 32'h33, 32'hDEADBEEF};
        tbl[11] = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd5, 32'h0, N,Y, 32'h33, 32'hA5A50005};
        // Both requesting every cycle: four CPU grants, then a forced I/O grant.
        tbl[12] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, N,N, 32'h33, 32'hA5A50005};
        tbl[13] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'hA5A50005};
        tbl[14] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'hA5A50005};
        tbl[15] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'hA5A50005};
        tbl[16] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  N,Y,N, 32'd2, 32'h0, Y,N, 32'h22, 32'hA5A50005};
        tbl[17] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, N,Y, 32'h22, 32'h33};
        tbl[18] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'h33};
        tbl[19] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'h33};
        tbl[20] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  Y,N,N, 32'd1, 32'h0, Y,N, 32'h22, 32'h33};
        tbl[21] = '{Y,N,32'd1,32'h0,  Y,N,32'd2,32'h0,  N,Y,N, 32'd2, 32'h0, Y,N, 32'h22, 32'h33};
        tbl[22] = '{N,N,32'd0,32'h0,  N,N,32'd0,32'h0,  N,N,N, 32'd2, 32'h0, N,Y, 32'h22, 32'h33};

        reset = Y;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        show("reset");
        chk("rst_cpu_gnt",    32'(cpu_gnt),    32'h0);
        chk("rst_io_gnt",     32'(io_gnt),     32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_io_rvalid",  32'(io_rvalid),  32'h0);
        chk("rst_ram_wren",   32'(ram_wren),   32'h0);
        chk("rst_ram_address", ram_address,    32'h0);
        chk("rst_ram_data",   ram_data,        32'h0);
        chk("rst_cpu_rdata",  cpu_rdata,       32'h0);
        chk("rst_io_rdata",   io_rdata,        32'h0);
        next_cycle();
        reset = N;

        for (int i = 0; i < 23; i++) begin
            next_cycle();
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            io_req  = tbl[i].ir; io_we  = tbl[i].iw; io_addr  = tbl[i].ia; io_wdata  = tbl[i].id;
            @(negedge clk);
            show($sformatf("vec %0d", i));
            chk($sformatf("v%0d_cpu_gnt", i),    32'(cpu_gnt),    32'(tbl[i].ecg));
            chk($sformatf("v%0d_io_gnt", i),     32'(io_gnt),     32'(tbl[i].eig));
            chk($sformatf("v%0d_ram_wren", i),   32'(ram_wren),   32'(tbl[i].ewr));
            chk($sformatf("v%0d_ram_address", i), ram_address,    tbl[i].ea);
            chk($sformatf("v%0d_ram_data", i),   ram_data,        tbl[i].ed);
            chk($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].ecv));
            chk($sformatf("v%0d_io_rvalid", i),  32'(io_rvalid),  32'(tbl[i].eiv));
            chk($sformatf("v%0d_cpu_rdata", i),  cpu_rdata,       tbl[i].ecd);
            chk($sformatf("v%0d_io_rdata", i),   io_rdata,        tbl[i].eid);
        end

        // A CPU read is granted, and reset arrives in the cycle its data would have returned.
        next_cycle();
        idle_inputs();
        cpu_req = Y; cpu_addr = 32'd0;
        @(negedge clk);
        show("rstseq grant");
        chk("rs_grant_cpu_gnt", 32'(cpu_gnt), 32'h1);
        next_cycle();
        reset = Y; cpu_addr = 32'd1; io_req = Y; io_addr = 32'd2;
        @(negedge clk);
        show("rstseq reset1");
        chk("rs_r1_cpu_gnt",    32'(cpu_gnt),    32'h0);
        chk("rs_r1_io_gnt",     32'(io_gnt),     32'h0);
        chk("rs_r1_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rs_r1_io_rvalid",  32'(io_rvalid),  32'h0);
        chk("rs_r1_ram_wren",   32'(ram_wren),   32'h0);
        next_cycle();
        @(negedge clk);
        show("rstseq reset2");
        chk("rs_r2_cpu_rvalid",  32'(cpu_rvalid), 32'h0);
        chk("rs_r2_ram_address", ram_address,     32'h0);
        chk("rs_r2_ram_data",    ram_data,        32'h0);
        chk("rs_r2_cpu_rdata",   cpu_rdata,       32'h0);
        chk("rs_r2_io_rdata",    io_rdata,        32'h0);
        next_cycle();
        reset = N; io_req = N; io_addr = 32'd0;
        @(negedge clk);
        show("rstseq release");
        chk("rs_rel_cpu_gnt",     32'(cpu_gnt), 32'h1);
        chk("rs_rel_ram_address", ram_address,  32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        show("rstseq return");
        chk("rs_ret_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rs_ret_cpu_rdata",  cpu_rdata,       32'h22);

        // From a clean reset, ten contended cycles: I/O is forced in the fifth and tenth cycles.
        next_cycle();
        reset = Y;
        next_cycle();
        reset = N;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            cpu_req = Y; cpu_addr = 32'd1; io_req = Y; io_addr = 32'd2;
            @(negedge clk);
            show($sformatf("contend %0d", k));
            chk($sformatf("c%0d_cpu_gnt", k), 32'(cpu_gnt), (k % 5 == 4) ? 32'h0 : 32'h1);
            chk($sformatf("c%0d_io_gnt", k),  32'(io_gnt),  (k % 5 == 4) ? 32'h1 : 32'h0);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        show("contend end");
`ifdef ARB_STATS_EN
        chk("stat_cpu_grant_cnt", cpu_grant_cnt,     32'd8);
        chk("stat_io_grant_cnt",  io_grant_cnt,      32'd2);
        chk("stat_io_force_cnt",  32'(io_force_cnt), 32'd2);
`endif
        chk("end_io_rvalid", 32'(io_rvalid), 32'h1);
        chk("end_io_rdata",  io_rdata,       32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
